// File: rtl/pencoder_seq.sv
// Sequential priority encoder: takes one essential-bit mask per transaction and
// streams the index of every set bit, one per beat, lowest or highest first.
module pencoder_seq #(
   parameter int WIDTH     = 8,
   parameter int IDX_W     = $clog2(WIDTH),
   parameter bit MSB_FIRST = 1'b0,
   parameter int CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] mask_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_val,
   output logic             out_last,
   output logic [CNT_W-1:0] out_seq,
   output logic [CNT_W-1:0] mask_cnt
);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] mask_r, mask_next;
   logic [WIDTH-1:0] sel;
   logic [IDX_W-1:0] idx_c;
   logic [CNT_W-1:0] seq_r, seq_next;
   logic [CNT_W-1:0] cnt_r, cnt_next;
   logic             scan;
   logic             last_c;
   logic             fire;
   logic             load;

   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] m);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + CNT_W'(m[i]);
      end
      return c;
   endfunction

   // Scan order decides which set bit wins: the last hit in the loop is kept.
   always_comb begin
      sel   = '0;
      idx_c = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (mask_r[i]) begin
               sel    = '0;
               sel[i] = 1'b1;
               idx_c  = IDX_W'(i);
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_r[i]) begin
               sel    = '0;
               sel[i] = 1'b1;
               idx_c  = IDX_W'(i);
            end
         end
      end
   end

   // Empty mask still produces one beat, so "at most one bit left" marks the last beat.
   always_comb begin
      scan      = (state == SCAN);
      last_c    = ((mask_r & ~sel) == '0);
      out_valid = scan;
      out_idx   = scan ? idx_c : '0;
      out_val   = scan && (mask_r != '0);
      out_last  = scan && last_c;
      out_seq   = seq_r;
      mask_cnt  = cnt_r;
      fire      = scan && out_ready;
      in_ready  = !scan || (fire && last_c);
      load      = in_valid && in_ready;
   end

   // A load in the same cycle as the final beat overrides the return to IDLE.
   always_comb begin
      state_next = state;
      mask_next  = mask_r;
      seq_next   = seq_r;
      cnt_next   = cnt_r;
      if (fire) begin
         mask_next = mask_r & ~sel;
         seq_next  = seq_r + CNT_W'(1);
         if (last_c) begin
            state_next = IDLE;
         end
      end
      if (load) begin
         mask_next  = mask_in;
         cnt_next   = popcount(mask_in);
         seq_next   = '0;
         state_next = SCAN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         mask_r <= '0;
         seq_r  <= '0;
         cnt_r  <= '0;
      end else begin
         state  <= state_next;
         mask_r <= mask_next;
         seq_r  <= seq_next;
         cnt_r  <= cnt_next;
      end
   end

endmodule

// File: tb/tb_pencoder_seq.sv
// Self-checking bench: an LSB-first and an MSB-first encoder share the same
// stimulus and are checked beat by beat against an ordered list of set bits.
module tb_pencoder_seq;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] mask_in;
   logic       out_ready;

   logic       l_in_ready, l_out_valid, l_out_val, l_out_last;
   logic [2:0] l_out_idx;
   logic [3:0] l_out_seq, l_mask_cnt;
   logic       m_in_ready, m_out_valid, m_out_val, m_out_last;
   logic [2:0] m_out_idx;
   logic [3:0] m_out_seq, m_mask_cnt;

   int check_count = 0;
   int pass_count  = 0;

   pencoder_seq #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
      .mask_in(mask_in), .out_valid(l_out_valid), .out_ready(out_ready),
      .out_idx(l_out_idx), .out_val(l_out_val), .out_last(l_out_last),
      .out_seq(l_out_seq), .mask_cnt(l_mask_cnt)
   );

   pencoder_seq #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
      .mask_in(mask_in), .out_valid(m_out_valid), .out_ready(out_ready),
      .out_idx(m_out_idx), .out_val(m_out_val), .out_last(m_out_last),
      .out_seq(m_out_seq), .mask_cnt(m_mask_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Both encoders idle: nothing valid, ready for a new mask.
   task automatic checkIdle(input string tag);
      checkOutput({tag, "_l_valid"}, 32'(l_out_valid), 32'd0);
      checkOutput({tag, "_m_valid"}, 32'(m_out_valid), 32'd0);
      checkOutput({tag, "_l_in_ready"}, 32'(l_in_ready), 32'd1);
      checkOutput({tag, "_m_in_ready"}, 32'(m_in_ready), 32'd1);
   endtask

   task automatic checkBeat(input string tag, input int l_idx, input int m_idx, input int val,
                            input int last, input int seq, input int cnt);
      checkOutput({tag, "_l_valid"}, 32'(l_out_valid), 32'd1);
      checkOutput({tag, "_m_valid"}, 32'(m_out_valid), 32'd1);
      checkOutput({tag, "_l_idx"}, 32'(l_out_idx), 32'(l_idx));
      checkOutput({tag, "_m_idx"}, 32'(m_out_idx), 32'(m_idx));
      checkOutput({tag, "_l_val"}, 32'(l_out_val), 32'(val));
      checkOutput({tag, "_m_val"}, 32'(m_out_val), 32'(val));
      checkOutput({tag, "_l_last"}, 32'(l_out_last), 32'(last));
      checkOutput({tag, "_m_last"}, 32'(m_out_last), 32'(last));
      checkOutput({tag, "_l_seq"}, 32'(l_out_seq), 32'(seq));
      checkOutput({tag, "_m_seq"}, 32'(m_out_seq), 32'(seq));
      checkOutput({tag, "_l_cnt"}, 32'(l_mask_cnt), 32'(cnt));
      checkOutput({tag, "_m_cnt"}, 32'(m_mask_cnt), 32'(cnt));
   endtask

   // ready_mode: 0 = always ready, 1 = toggle 1,0,1,0..., 2 = random.
   task automatic applyStimulus(input string tag, input logic [7:0] m, input int ready_mode);
      int   bits[$];
      int   n, beats, k, cyc;
      logic rdy;
      bits = {};
      for (int b = 0; b < 8; b++) begin
         if (m[b]) bits.push_back(b);
      end
      n     = bits.size();
      beats = (n == 0) ? 1 : n;
      checkIdle({tag, "_pre"});
      in_valid = 1'b1;
      mask_in  = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      k   = 0;
      cyc = 0;
      while (k < beats && cyc < 100) begin
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         #1;
         if (n == 0) checkBeat(tag, 0, 0, 0, 1, 0, 0);
         else checkBeat(tag, bits[k], bits[n-1-k], 1, (k == beats - 1) ? 1 : 0, k, n);
         checkOutput({tag, "_l_in_ready_busy"}, 32'(l_in_ready), 32'(rdy && (k == beats - 1)));
         if (rdy) k++;
         cyc++;
         @(posedge clk);
         #1;
      end
      checkOutput({tag, "_beats_done"}, 32'(k), 32'(beats));
      checkIdle({tag, "_post"});
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      mask_in   = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkIdle("reset");
      checkOutput("reset_l_idx", 32'(l_out_idx), 32'd0);
      checkOutput("reset_l_val", 32'(l_out_val), 32'd0);
      checkOutput("reset_l_last", 32'(l_out_last), 32'd0);
      checkOutput("reset_l_seq", 32'(l_out_seq), 32'd0);
      checkOutput("reset_l_cnt", 32'(l_mask_cnt), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus("t1_t2", 8'hA4, 0);
      applyStimulus("t3_empty", 8'h00, 0);
      applyStimulus("t4_full", 8'hFF, 1);

      // Back-to-back: second mask is presented while the first is still streaming.
      in_valid  = 1'b1;
      mask_in   = 8'h81;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      mask_in = 8'h10;
      #1;
      checkBeat("t5_b0", 0, 7, 1, 0, 0, 2);
      checkOutput("t5_b0_in_ready", 32'(l_in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkBeat("t5_b1", 7, 0, 1, 1, 1, 2);
      checkOutput("t5_b1_in_ready", 32'(l_in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #1;
      checkBeat("t5_b2", 4, 4, 1, 1, 0, 1);
      @(posedge clk);
      #1;
      checkIdle("t5_end");

      // Reset in the middle of a scan discards the remaining beats.
      in_valid = 1'b1;
      mask_in  = 8'hF0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkBeat("t6_b0", 4, 7, 1, 0, 0, 4);
      @(posedge clk);
      #1;
      checkOutput("t6_b1_l_idx", 32'(l_out_idx), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      checkIdle("t6_reset");
      checkOutput("t6_reset_l_seq", 32'(l_out_seq), 32'd0);
      checkOutput("t6_reset_l_cnt", 32'(l_mask_cnt), 32'd0);
      checkOutput("t6_reset_l_last", 32'(l_out_last), 32'd0);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus("t6_after", 8'h02, 0);

      for (int r = 0; r < 8; r++) begin
         applyStimulus($sformatf("rand%0d", r), 8'($urandom), 2);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
